// File: rtl/audio_sample_capture.sv
// Audio sample capture peripheral.
// Samples the synthesizer stream at a programmable rate into a FIFO that the
// Nios drains over Avalon-MM. Raises a level interrupt when the FIFO fill
// level reaches a programmable threshold.
module audio_sample_capture #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic [15:0] audio_in
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DepthL = LW'(DEPTH);

  localparam logic [2:0] AddrData      = 3'd0;
  localparam logic [2:0] AddrControl   = 3'd1;
  localparam logic [2:0] AddrStatus    = 3'd2;
  localparam logic [2:0] AddrDivider   = 3'd3;
  localparam logic [2:0] AddrThreshold = 3'd4;

  // Architectural state
  logic          enable_q,    enable_d;
  logic          irqEn_q,     irqEn_d;
  logic [31:0]   divider_q,   divider_d;
  logic [8:0]    threshold_q, threshold_d;
  logic [31:0]   tickCnt_q,   tickCnt_d;
  logic [AW-1:0] rdPtr_q,     rdPtr_d;
  logic [AW-1:0] wrPtr_q,     wrPtr_d;
  logic [LW-1:0] level_q,     level_d;
  logic          overflow_q,  overflow_d;
  logic          underflow_q, underflow_d;

  // Sample storage; kept free of reset so it maps onto RAM
  logic [15:0] mem [DEPTH];

  // Bus decode and FIFO event signals
  logic        wrAccess, rdAccess;
  logic        wrControl, wrStatus, wrDivider, wrThreshold;
  logic        rdData;
  logic        clearPulse;
  logic        tick;
  logic        fifoEmpty, fifoFull;
  logic        popDo, pushDo;
  logic        overflowEv, underflowEv;
  logic [8:0]  levelWide;
  logic [15:0] headData;

  assign wrAccess    = chipselect & write;
  assign rdAccess    = chipselect & read;
  assign wrControl   = wrAccess && (address == AddrControl);
  assign wrStatus    = wrAccess && (address == AddrStatus);
  assign wrDivider   = wrAccess && (address == AddrDivider);
  assign wrThreshold = wrAccess && (address == AddrThreshold);
  assign rdData      = rdAccess && (address == AddrData);
  assign clearPulse  = wrControl && writedata[2];

  assign tick      = enable_q && (tickCnt_q == divider_q);
  assign fifoEmpty = (level_q == '0);
  assign fifoFull  = (level_q == DepthL);
  assign levelWide = 9'(level_q);
  assign headData  = mem[rdPtr_q];

  // A pop frees a slot on the same edge, so a full FIFO can still accept a tick
  assign popDo       = rdData && !fifoEmpty;
  assign pushDo      = tick && (!fifoFull || popDo);
  assign overflowEv  = tick && fifoFull && !popDo;
  assign underflowEv = rdData && fifoEmpty;

  // Configuration registers: CONTROL, DIVIDER and THRESHOLD next state
  always_comb begin
    enable_d    = enable_q;
    irqEn_d     = irqEn_q;
    divider_d   = divider_q;
    threshold_d = threshold_q;
    if (wrControl) begin
      enable_d = writedata[0];
      irqEn_d  = writedata[1];
    end
    if (wrDivider) begin
      divider_d = writedata;
    end
    if (wrThreshold) begin
      threshold_d = writedata[8:0];
    end
  end

  // Sample-rate counter: runs 0..DIVIDER while enabled, restarts on a DIVIDER write
  always_comb begin
    tickCnt_d = tickCnt_q;
    if (wrDivider || !enable_q || tick) begin
      tickCnt_d = '0;
    end else begin
      tickCnt_d = tickCnt_q + 32'd1;
    end
  end

  // FIFO pointers, level and sticky error flags; clear overrides push and pop
  always_comb begin
    rdPtr_d     = rdPtr_q;
    wrPtr_d     = wrPtr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clearPulse) begin
      rdPtr_d     = '0;
      wrPtr_d     = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (popDo) begin
        rdPtr_d = rdPtr_q + AW'(1);
      end
      if (pushDo) begin
        wrPtr_d = wrPtr_q + AW'(1);
      end
      case ({pushDo, popDo})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      overflow_d  = (overflow_q  & ~(wrStatus & writedata[11])) | overflowEv;
      underflow_d = (underflow_q & ~(wrStatus & writedata[12])) | underflowEv;
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q    <= 1'b0;
      irqEn_q     <= 1'b0;
      divider_q   <= '0;
      threshold_q <= '0;
      tickCnt_q   <= '0;
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      enable_q    <= enable_d;
      irqEn_q     <= irqEn_d;
      divider_q   <= divider_d;
      threshold_q <= threshold_d;
      tickCnt_q   <= tickCnt_d;
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Sample RAM write port
  always_ff @(posedge clk) begin
    if (pushDo && !clearPulse) begin
      mem[wrPtr_q] <= audio_in;
    end
  end

  // Zero-wait-state read mux; DATA shows the head before any pop on this edge
  always_comb begin
    readdata = 32'd0;
    case (address)
      AddrData:      readdata = fifoEmpty ? 32'd0 : {16'd0, headData};
      AddrControl:   readdata = {30'd0, irqEn_q, enable_q};
      AddrStatus:    readdata = {19'd0, underflow_q, overflow_q, fifoFull, fifoEmpty, levelWide};
      AddrDivider:   readdata = divider_q;
      AddrThreshold: readdata = {23'd0, threshold_q};
      default:       readdata = 32'd0;
    endcase
  end

  // Level interrupt; a zero threshold disables it
  assign irq = irqEn_q && (threshold_q != 9'd0) && (levelWide >= threshold_q);

endmodule

// File: tb/tb_audio_sample_capture.sv
// Testbench for audio_sample_capture: directed scenarios plus a randomized
// run, all checked against a queue-based behavioural model of the peripheral.
module tb_audio_sample_capture;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        irq;
  logic [15:0] audioIn = 16'd0;

  int checks = 0;
  int passes = 0;
  bit rampMode = 1'b1;

  // Behavioural model state
  logic [15:0] mq[$];
  bit          mEn = 1'b0;
  bit          mIen = 1'b0;
  logic [31:0] mDiv = 32'd0;
  logic [8:0]  mThr = 9'd0;
  logic [31:0] mPhase = 32'd0;
  bit          mOvf = 1'b0;
  bit          mUdf = 1'b0;

  audio_sample_capture #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .audio_in   (audioIn)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic modelReset();
    mq.delete();
    mEn = 1'b0; mIen = 1'b0; mDiv = 32'd0; mThr = 9'd0;
    mPhase = 32'd0; mOvf = 1'b0; mUdf = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently on the bus
  task automatic modelUpdate();
    bit wr, rd, tickNow, clr, dataRd;
    if (reset) begin
      modelReset();
      return;
    end
    wr      = chipselect && write;
    rd      = chipselect && read;
    tickNow = mEn && (mPhase == mDiv);
    clr     = wr && (address == 3'd1) && writedata[2];
    dataRd  = rd && (address == 3'd0);
    if (clr) begin
      mq.delete();
      mOvf = 1'b0;
      mUdf = 1'b0;
    end else begin
      if (wr && address == 3'd2) begin
        if (writedata[11]) mOvf = 1'b0;
        if (writedata[12]) mUdf = 1'b0;
      end
      if (dataRd && mq.size() == 0) mUdf = 1'b1;
      if (dataRd && mq.size() > 0) void'(mq.pop_front());
      if (tickNow) begin
        if (mq.size() < DEPTH) mq.push_back(audioIn);
        else mOvf = 1'b1;
      end
    end
    if ((wr && address == 3'd3) || !mEn || tickNow) mPhase = 32'd0;
    else mPhase = mPhase + 32'd1;
    if (wr) begin
      case (address)
        3'd1: begin mEn = writedata[0]; mIen = writedata[1]; end
        3'd3: mDiv = writedata;
        3'd4: mThr = writedata[8:0];
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [2:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a)
      3'd0: v = (mq.size() > 0) ? {16'd0, mq[0]} : 32'd0;
      3'd1: v = {30'd0, mIen, mEn};
      3'd2: v = {19'd0, mUdf, mOvf, (mq.size() == DEPTH), (mq.size() == 0), 9'(mq.size())};
      3'd3: v = mDiv;
      3'd4: v = {23'd0, mThr};
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  function automatic bit modelIrq();
    return mIen && (mThr != 9'd0) && (mq.size() >= int'(mThr));
  endfunction

  // One clock: model and DUT see the same edge, then the sample stream moves on
  task automatic step();
    modelUpdate();
    @(posedge clk);
    #1;
    if (rampMode) audioIn = audioIn + 16'd1;
    else audioIn = 16'($urandom);
  endtask

  task automatic setIdle();
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
  endtask

  task automatic busWrite(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1; read = 1'b0;
    step();
    setIdle();
  endtask

  task automatic busRead(input logic [2:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read = 1'b1; write = 1'b0;
    #2;
    d = readdata;
    step();
    setIdle();
  endtask

  task automatic peek(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    #1;
    modelReset();
    for (int a = 0; a < 5; a++) begin
      peek(3'(a), v);
      checks++;
      if (v !== (a == 2 ? 32'h200 : 32'h0)) $display("[TB] FAIL reset_reg%0d: got %h expected %h", a, v, (a == 2 ? 32'h200 : 32'h0));
      else passes++;
    end
    checks++;
    if (irq !== 1'b0) $display("[TB] FAIL reset_irq: got %b expected 0", irq);
    else passes++;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_ramp_capture();
    logic [31:0] v;
    logic [15:0] exp;
    rampMode = 1'b1;
    busWrite(3'd1, 32'h4);
    busWrite(3'd3, 32'd3);
    busWrite(3'd1, 32'h1);
    audioIn = 16'd0;
    for (int i = 0; i < 16; i++) step();
    busWrite(3'd1, 32'h0);
    for (int k = 0; k < 4; k++) begin
      exp = 16'(4 * k + 3);
      busRead(3'd0, v);
      checks++;
      if (v !== {16'd0, exp}) $display("[TB] FAIL ramp_read%0d: got %h expected %h", k, v, exp);
      else passes++;
    end
    peek(3'd2, v);
    checks++;
    if (v !== 32'h200) $display("[TB] FAIL ramp_empty: got %h expected 00000200", v);
    else passes++;
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    busWrite(3'd1, 32'h4);
    busWrite(3'd3, 32'd0);
    busWrite(3'd1, 32'h1);
    audioIn = 16'd0;
    for (int i = 0; i < 70; i++) step();
    peek(3'd2, v);
    checks++;
    if (v !== 32'hC40) $display("[TB] FAIL ovf_status: got %h expected 00000c40", v);
    else passes++;
    busRead(3'd0, v);
    checks++;
    if (v !== 32'h0) $display("[TB] FAIL ovf_first_sample: got %h expected 00000000", v);
    else passes++;
    peek(3'd2, v);
    checks++;
    if (v[8:0] !== 9'd64) $display("[TB] FAIL ovf_level_after_pop: got %0d expected 64", v[8:0]);
    else passes++;
    busWrite(3'd3, 32'd3);
    busWrite(3'd2, 32'h800);
    peek(3'd2, v);
    checks++;
    if (v !== 32'h440) $display("[TB] FAIL ovf_w1c: got %h expected 00000440", v);
    else passes++;
    step();
    step();
    busRead(3'd0, v);
    checks++;
    if (v !== 32'h1) $display("[TB] FAIL full_popush_data: got %h expected 00000001", v);
    else passes++;
    peek(3'd2, v);
    checks++;
    if (v !== 32'h440) $display("[TB] FAIL full_popush_status: got %h expected 00000440", v);
    else passes++;
    busWrite(3'd1, 32'h4);
  endtask

  task automatic test_underflow();
    logic [31:0] v;
    busWrite(3'd1, 32'h4);
    busRead(3'd0, v);
    checks++;
    if (v !== 32'h0) $display("[TB] FAIL udf_data: got %h expected 00000000", v);
    else passes++;
    peek(3'd2, v);
    checks++;
    if (v !== 32'h1200) $display("[TB] FAIL udf_set: got %h expected 00001200", v);
    else passes++;
    busWrite(3'd2, 32'h1000);
    peek(3'd2, v);
    checks++;
    if (v !== 32'h200) $display("[TB] FAIL udf_clear: got %h expected 00000200", v);
    else passes++;
  endtask

  task automatic test_irq();
    logic [31:0] v;
    int rise;
    rise = -1;
    busWrite(3'd1, 32'h4);
    busWrite(3'd4, 32'd8);
    busWrite(3'd3, 32'd9);
    busWrite(3'd1, 32'h3);
    for (int k = 1; k <= 120 && rise < 0; k++) begin
      step();
      checks++;
      if (irq !== modelIrq()) $display("[TB] FAIL irq_track%0d: got %b expected %b", k, irq, modelIrq());
      else passes++;
      if (irq === 1'b1) rise = k;
    end
    checks++;
    if (rise != 80) $display("[TB] FAIL irq_rise_cycle: got %0d expected 80", rise);
    else passes++;
    busRead(3'd0, v);
    checks++;
    if (irq !== 1'b0) $display("[TB] FAIL irq_drop: got %b expected 0", irq);
    else passes++;
    busWrite(3'd4, 32'd0);
    busWrite(3'd1, 32'h4);
  endtask

  task automatic test_clear_and_reset();
    logic [31:0] v;
    busWrite(3'd3, 32'd0);
    busWrite(3'd1, 32'h1);
    for (int i = 0; i < 20; i++) step();
    peek(3'd2, v);
    checks++;
    if (v !== 32'h014) $display("[TB] FAIL clr_level20: got %h expected 00000014", v);
    else passes++;
    busWrite(3'd1, 32'h5);
    peek(3'd2, v);
    checks++;
    if (v !== 32'h200) $display("[TB] FAIL clr_empty: got %h expected 00000200", v);
    else passes++;
    step();
    peek(3'd2, v);
    checks++;
    if (v !== 32'h001) $display("[TB] FAIL clr_continue: got %h expected 00000001", v);
    else passes++;
    reset = 1'b1;
    #1;
    modelReset();
    peek(3'd2, v);
    checks++;
    if (v !== 32'h200) $display("[TB] FAIL rst_mid_status: got %h expected 00000200", v);
    else passes++;
    peek(3'd1, v);
    checks++;
    if (v !== 32'h0 || irq !== 1'b0) $display("[TB] FAIL rst_mid_ctrl: got %h/%b expected 0/0", v, irq);
    else passes++;
    step();
    reset = 1'b0;
    busWrite(3'd3, 32'd2);
    busWrite(3'd1, 32'h1);
    step();
    step();
    peek(3'd2, v);
    checks++;
    if (v !== 32'h200) $display("[TB] FAIL rst_first_tick_early: got %h expected 00000200", v);
    else passes++;
    step();
    peek(3'd2, v);
    checks++;
    if (v !== 32'h001) $display("[TB] FAIL rst_first_tick: got %h expected 00000001", v);
    else passes++;
  endtask

  task automatic test_random();
    int r;
    rampMode = 1'b0;
    busWrite(3'd1, 32'h4);
    busWrite(3'd3, 32'd1);
    busWrite(3'd4, 32'd10);
    busWrite(3'd1, 32'h3);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      address = 3'd0; writedata = 32'd0;
      if (r < 40) begin
        address = 3'($urandom_range(0, 7));
      end else if (r < 70) begin
        address = 3'd0; chipselect = 1'b1; read = 1'b1;
      end else if (r < 78) begin
        address = 3'($urandom_range(0, 7)); chipselect = 1'b1; read = 1'b1;
      end else if (r < 84) begin
        address = 3'd2; writedata = {19'd0, 2'($urandom), 11'($urandom)}; chipselect = 1'b1; write = 1'b1;
      end else if (r < 88) begin
        address = 3'd3; writedata = 32'($urandom_range(0, 5)); chipselect = 1'b1; write = 1'b1;
      end else if (r < 92) begin
        address = 3'd4; writedata = 32'($urandom_range(0, 70)); chipselect = 1'b1; write = 1'b1;
      end else if (r < 96) begin
        address = 3'd1; chipselect = 1'b1; write = 1'b1;
        writedata = {29'd0, ($urandom_range(0, 7) == 0), 1'($urandom), ($urandom_range(0, 7) != 0)};
      end else begin
        address = 3'($urandom_range(5, 7)); writedata = $urandom; chipselect = 1'b1; write = 1'b1;
      end
      #2;
      checks++;
      if (readdata !== modelRead(address)) $display("[TB] FAIL rand_readdata%0d: addr %0d got %h expected %h", i, address, readdata, modelRead(address));
      else passes++;
      checks++;
      if (irq !== modelIrq()) $display("[TB] FAIL rand_irq%0d: got %b expected %b", i, irq, modelIrq());
      else passes++;
      step();
      setIdle();
    end
  endtask

  // Scenario sequence and summary
  initial begin
    test_reset();
    test_ramp_capture();
    test_overflow();
    test_underflow();
    test_irq();
    test_clear_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
